// File: rtl/adpll_pkg.sv
// Shared types, constants and saturating helpers for the adpll_pi loop.
// Holds the FSM state enum, nominal FTW, dither LFSR seed/taps.
`timescale 1ns/1ps
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    HOLDOVER
  } state_t;

  localparam longint FTW_NOM_DEF = 64'd71582788;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int WIDE = 64;

  function automatic logic signed [WIDE-1:0] clamp(
    input logic signed [WIDE-1:0] x,
    input logic signed [WIDE-1:0] lo,
    input logic signed [WIDE-1:0] hi
  );
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // saturate x to the range of a w-bit signed value
  function automatic logic signed [WIDE-1:0] sat(
    input logic signed [WIDE-1:0] x,
    input int w
  );
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return clamp(x, lo, hi);
  endfunction

endpackage

// File: rtl/adpll_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus rising-edge detect.
// Ports: clk, rst (async, active-high), d (async in), rise (1-clk pulse).
`timescale 1ns/1ps
module adpll_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], d};
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/adpll_pi.sv
// PI-filtered ADPLL: NCO locked to async i_rf, with lock detect and holdover.
// Ports: i_clk, i_rst, i_en, i_rf in; o_gen, o_lock, o_holdover, o_ftw, o_err out.
// Define ADPLL_DITHER_EN to add LFSR dither to the NCO increment LSB.
`timescale 1ns/1ps
module adpll_pi
  import adpll_pkg::*;
#(
  parameter int     ACC_W    = 32,
  parameter int     ERR_W    = 16,
  parameter longint FTW_NOM  = FTW_NOM_DEF,
  parameter int     KP_SHL   = 8,
  parameter int     KI_SHL   = 2,
  parameter int     LOCK_TOL = 256,
  parameter int     LOCK_CNT = 16,
  parameter int     TIMEOUT  = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_rf,
  output logic                    o_gen,
  output logic                    o_lock,
  output logic                    o_holdover,
  output logic [ACC_W-1:0]        o_ftw,
  output logic signed [ERR_W-1:0] o_err
);

  localparam int W2  = ACC_W + 2;
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [ACC_W-1:0] NOM_ACC = ACC_W'(FTW_NOM);
  localparam logic signed [W2-1:0] NOM_W = W2'(FTW_NOM);
  localparam logic signed [WIDE-1:0] FTW_MIN = 64'sd1;
  localparam logic signed [WIDE-1:0] FTW_MAX =
    (64'sd1 <<< (ACC_W - 1)) - 64'sd1;

  logic rf_edge;

  adpll_sync_edge u_sync (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_rf),
    .rise (rf_edge)
  );

  state_t state, state_n;

  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        ftw;
  logic [ACC_W-1:0]        step;
  logic signed [ACC_W-1:0] integ;
  logic signed [ERR_W-1:0] err;
  logic signed [ERR_W:0]   err_x;
  logic [ERR_W:0]          err_abs;
  logic                    in_win;
  logic                    upd;
  logic [LCW-1:0]          lock_cnt, lock_cnt_n;
  logic [TCW-1:0]          tmo_cnt;
  logic                    tmo_hit;

  // phase detector: NCO phase at the reference edge, negated
  assign err     = -$signed(acc[ACC_W-1 -: ERR_W]);
  assign err_x   = {err[ERR_W-1], err};
  assign err_abs = err_x[ERR_W] ? -err_x : err_x;
  assign in_win  = err_abs <= (ERR_W+1)'(LOCK_TOL);
  assign tmo_hit = !rf_edge && (tmo_cnt == TCW'(TIMEOUT - 1));

  // loop filter arithmetic, two guard bits over the accumulator
  logic signed [W2-1:0] err_w;
  logic signed [W2-1:0] integ_w;
  logic signed [W2-1:0] i_sum;
  logic signed [W2-1:0] f_sum;
  logic signed [W2-1:0] h_sum;
  logic [ACC_W-1:0]     integ_nx;
  logic [ACC_W-1:0]     ftw_nx;
  logic [ACC_W-1:0]     ftw_ho;

  assign err_w   = {{(W2-ERR_W){o_err[ERR_W-1]}}, o_err};
  assign integ_w = {{2{integ[ACC_W-1]}}, integ};
  assign i_sum   = integ_w + (err_w <<< KI_SHL);
  assign f_sum   = NOM_W + integ_w + (err_w <<< KP_SHL);
  assign h_sum   = NOM_W + integ_w;

  assign integ_nx = ACC_W'(sat(WIDE'(i_sum), ACC_W));
  assign ftw_nx   = ACC_W'(clamp(WIDE'(f_sum), FTW_MIN, FTW_MAX));
  assign ftw_ho   = ACC_W'(clamp(WIDE'(h_sum), FTW_MIN, FTW_MAX));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    if (!i_en) begin
      state_n    = IDLE;
      lock_cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n    = ACQUIRE;
          lock_cnt_n = '0;
        end
        ACQUIRE: begin
          if (rf_edge) begin
            if (in_win) begin
              lock_cnt_n = lock_cnt + 1'b1;
              if (lock_cnt == LCW'(LOCK_CNT - 1)) state_n = LOCKED;
            end else begin
              lock_cnt_n = '0;
            end
          end else if (tmo_hit) begin
            state_n    = HOLDOVER;
            lock_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (rf_edge) begin
            if (!in_win) begin
              state_n    = ACQUIRE;
              lock_cnt_n = '0;
            end
          end else if (tmo_hit) begin
            state_n    = HOLDOVER;
            lock_cnt_n = '0;
          end
        end
        HOLDOVER: begin
          // this edge only resynchronises
          if (rf_edge) begin
            state_n    = ACQUIRE;
            lock_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if (!i_en || state == IDLE || rf_edge) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TCW'(TIMEOUT)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= '0;
      upd   <= 1'b0;
      integ <= '0;
      ftw   <= NOM_ACC;
    end else begin
      if (rf_edge) o_err <= err;
      upd <= i_en && rf_edge &&
             (state == ACQUIRE || state == LOCKED);
      if (!i_en || state == IDLE) begin
        integ <= '0;
        ftw   <= NOM_ACC;
      end else if (state == HOLDOVER) begin
        ftw <= ftw_ho;
      end else if (upd) begin
        integ <= integ_nx;
        ftw   <= ftw_nx;
      end
    end
  end

`ifdef ADPLL_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lfsr <= LFSR_SEED;
    else       lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign step = ftw + ACC_W'(lfsr[0]);
`else
  assign step = ftw;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) acc <= '0;
    else       acc <= acc + step;
  end

  assign o_gen      = acc[ACC_W-1];
  assign o_lock     = (state == LOCKED);
  assign o_holdover = (state == HOLDOVER);
  assign o_ftw      = ftw;

endmodule

// File: tb/tb_adpll_pi.sv
// Directed bench for adpll_pi with a scoreboard queue of expectations.
// Reference clock comes from a period-programmable generator process.
`timescale 1ns/1ps
module tb_adpll_pi;

  localparam longint NOM = 64'd71582788;
  localparam longint TGT = 64'd72795717;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic rf  = 1'b0;
  logic gen;
  logic lock;
  logic hold;
  logic [31:0] ftw;
  logic signed [15:0] err;

  adpll_pi dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_rf       (rf),
    .o_gen      (gen),
    .o_lock     (lock),
    .o_holdover (hold),
    .o_ftw      (ftw),
    .o_err      (err)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          ref_period = 0;
  int unsigned rise_cyc   = 0;
  int unsigned rises      = 0;
  int unsigned cyc_rst    = 0;

  // reference rises land 3 ns after a clock edge
  initial begin
    int p;
    @(posedge clk);
    #3;
    forever begin
      p = ref_period;
      if (p == 0) begin
        @(posedge clk);
        #3;
      end else begin
        rf = 1'b1;
        rise_cyc = cyc;
        rises++;
        #(p / 2);
        rf = 1'b0;
        #(p - p / 2);
      end
    end
  end

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow observed=%0d expected=none", obs);
    end else begin
      e = sbq.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int n;
    n = 0;
    while (!lock && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(lock), 64'd1);
  endtask

  // one reference pulse while idle; the NCO runs at FTW_NOM from reset
  task automatic pulse();
    int unsigned r0;
    logic [31:0] a;
    logic signed [15:0] e;
    r0 = rises;
    ref_period = 1200;
    wait (rises != r0);
    ref_period = 0;
    a = 32'((longint'(rise_cyc) + 64'sd2 - longint'(cyc_rst)) * NOM);
    e = -$signed(a[31:16]);
    sb_push("pd_err", 64'(e));
    tick(8);
    sb_pop(64'(err));
  endtask

  task automatic push_reset();
    sb_push("rst_gen", 64'd0);
    sb_push("rst_lock", 64'd0);
    sb_push("rst_hold", 64'd0);
    sb_push("rst_ftw", 64'(NOM));
    sb_push("rst_err", 64'd0);
  endtask

  task automatic pop_reset();
    sb_pop(64'(gen));
    sb_pop(64'(lock));
    sb_pop(64'(hold));
    sb_pop(64'(ftw));
    sb_pop(64'(err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int last;
    int per;
    int ae;
    longint d;
    logic pg;
    logic [31:0] fz;

    #2;
    rst = 1'b1;
    push_reset();
    #1;
    pop_reset();
    tick(5);
    rst = 1'b0;
    cyc_rst = cyc;
    tick(30);

    pulse();
    tick(137);
    pulse();
    tick(51);
    pulse();

    en = 1'b1;
    ref_period = 1200;
    wait_lock("lock_1200", 24000);

    cnt  = 0;
    last = -1;
    n    = 0;
    pg   = gen;
    while (cnt < 5 && n < 600) begin
      @(negedge clk);
      n++;
      if (gen && !pg) begin
        if (last >= 0) begin
          per = (int'(cyc) - last) * 20;
          check("gen_period", 64'(per >= 1180 && per <= 1220), 64'd1);
        end
        last = int'(cyc);
        cnt++;
      end
      pg = gen;
    end
    check("gen_edges", 64'(cnt), 64'd5);

    for (int i = 0; i < 10; i++) begin
      tick(60);
      ae = (err < 0) ? -int'(err) : int'(err);
      check("err_window", 64'(ae <= 256), 64'd1);
    end

    ref_period = 1180;
    tick(1800);
    wait_lock("lock_1180", 30000);
    tick(5900);
    d = longint'(ftw) - TGT;
    check("ftw_1180", 64'(d >= -64'sd363978 && d <= 64'sd363978), 64'd1);

    ref_period = 0;
    n = 0;
    while (!hold && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ho_seen", 64'(hold), 64'd1);
    check("ho_delay", 64'(cyc - rise_cyc), 64'd1027);
    check("ho_lock", 64'(lock), 64'd0);
    tick(3);
    fz = ftw;
    tick(500);
    check("ho_frozen", 64'(ftw), 64'(fz));
    d = longint'(ftw) - TGT;
    check("ho_ftw", 64'(d >= -64'sd363978 && d <= 64'sd363978), 64'd1);

    ref_period = 1200;
    tick(120);
    check("ho_exit", 64'(hold), 64'd0);
    wait_lock("relock_ho", 25000);

    en = 1'b0;
    sb_push("en0_lock", 64'd0);
    sb_push("en0_ftw", 64'(NOM));
    tick(1);
    sb_pop(64'(lock));
    sb_pop(64'(ftw));
    tick(10);
    en = 1'b1;
    wait_lock("relock_en", 25000);

    ref_period = 40;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      check("fast_ftw_range",
            64'(ftw >= 32'd1 && ftw <= 32'h7FFF_FFFF), 64'd1);
    end

    #7;
    rst = 1'b1;
    push_reset();
    #1;
    pop_reset();
    #992;
    push_reset();
    pop_reset();
    @(negedge clk);
    rst = 1'b0;
    ref_period = 0;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adpll_pi.md
Name: adpll_pi

Overview:
Parametrised all-digital PLL, successor of the fixed-ratio adpll. An NCO phase accumulator is locked to an asynchronous reference i_rf by a sampled-phase detector and a proportional-integral loop filter. Adds an enable, a lock detector, holdover on loss of reference, and exposes the frequency tuning word (FTW) and phase error. Sits between the RF input pin and downstream logic clocked by the 50 MHz system clock.

Parameters:
ACC_W, 32, NCO accumulator width in bits
ERR_W, 16, phase error width: top ERR_W accumulator bits, signed
FTW_NOM, 71582788, nominal FTW (833.33 kHz at 50 MHz)
KP_SHL, 8, proportional gain as a left shift of the error
KI_SHL, 2, integral gain as a left shift of the error
LOCK_TOL, 256, lock window on |err|
LOCK_CNT, 16, consecutive in-window ref edges needed to declare lock
TIMEOUT, 1024, clocks without a ref edge before holdover

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_en  in  1  loop enable
i_rf  in  1  reference input, asynchronous to i_clk
o_gen  out  1  generated clock, equal to accumulator MSB
o_lock  out  1  lock indicator
o_holdover  out  1  reference lost; frequency frozen
o_ftw  out  ACC_W  FTW currently applied to the NCO
o_err  out  ERR_W  last sampled phase error, signed

Behaviour:
- Reset: all outputs and internal registers are asynchronously cleared (accumulator, integrator, synchroniser, lock counter, timeout counter); o_gen=0, o_lock=0, o_holdover=0, o_err=0, o_ftw=FTW_NOM; state=IDLE.
- i_rf passes through a 2-FF synchroniser, then a rising-edge detect (rf_edge), giving 3 clocks of input latency.
- NCO: every clock, acc <= acc + ftw, modulo 2^ACC_W.
- Phase detector, on rf_edge: err = -signed(acc[ACC_W-1 -: ERR_W]); o_err <= err. Positive err means the NCO lags.
- Loop filter, in the clock after rf_edge:
  - integ <= sat(integ + (err <<< KI_SHL)), with integ an ACC_W-bit signed value.
  - ftw <= clamp(FTW_NOM + integ + (err <<< KP_SHL), 1, 2^(ACC_W-1)-1).
  - All arithmetic uses ACC_W+2 bits with sign extension. The clamp guarantees ftw is never 0 and never at or above Nyquist.
- The new ftw takes effect on the following clock, so the total sample-to-NCO latency is 2 clocks.
- FSM states: IDLE, ACQUIRE, LOCKED, HOLDOVER.
  - IDLE: entered whenever i_en=0, from any state. integ=0, ftw=FTW_NOM, acc keeps running, lock counter cleared. Exits to ACQUIRE when i_en=1.
  - ACQUIRE: the loop runs. Every rf_edge with |err|<=LOCK_TOL increments the lock counter; any edge outside the window clears it. When the counter reaches LOCK_CNT the FSM moves to LOCKED.
  - LOCKED: o_lock=1. One edge with |err|>LOCK_TOL returns the FSM to ACQUIRE (counter and o_lock cleared in the same clock).
  - HOLDOVER: entered from ACQUIRE or LOCKED when the timeout counter reaches TIMEOUT.
    - ftw <= clamp(FTW_NOM + integ), i.e. the P term is dropped and integ is held.
    - o_holdover=1, o_lock=0.
    - The next rf_edge returns the FSM to ACQUIRE. That edge is used only to resynchronise: no filter update, no lock count.
- Timeout counter: cleared on rf_edge and in IDLE, otherwise saturating increment.
- Simultaneous events: i_en=0 overrides everything. rf_edge in the same clock as the timeout count reaching TIMEOUT counts as an edge, so no holdover is entered.
- Reset mid-operation returns every output to its reset value within the same clock.

Optional Feature:
ADPLL_DITHER_EN:
- Defined: a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 0xACE1, reset to the seed) advances every clock. Its bit 0 is added to the ftw LSB before the accumulator, to break up NCO spurs. o_ftw reports the undithered value.
- Undefined: no LFSR; the accumulator adds ftw exactly.

Decomposition:
- Package adpll_pkg holds:
  - the state enum (IDLE, ACQUIRE, LOCKED, HOLDOVER);
  - the saturate and clamp helper functions;
  - the default constants (FTW_NOM, LFSR seed and taps).
- One sub-module, adpll_sync_edge: 2-FF synchroniser plus rising-edge detect, with async reset. It is reused for other asynchronous inputs.

Test Plan:
1. Assert i_rst for 1000 ns mid-run -> o_gen=0, o_lock=0, o_holdover=0, o_ftw=71582788, o_err=0 immediately.
2. i_en=1, i_rf period 1200 ns -> o_lock=1 within 400 ref cycles; afterwards |o_err|<=256 and o_gen period is 1200 ns ±20 ns.
3. i_rf period 1180 ns -> lock is reached; o_ftw settles within ±0.5% of 72795717.
4. After lock, hold i_rf low -> o_holdover=1 and o_lock=0 exactly 1024+3 clocks after the last edge; o_ftw stays frozen. Restarting the 1200 ns reference -> ACQUIRE, then relock.
5. Toggle i_en to 0 mid-lock -> next clock o_lock=0 and o_ftw=71582788. Re-enable -> relock.
6. i_rf period 40 ns -> o_ftw never exceeds 2147483647 and never goes negative; no accumulator misbehaviour.
